acl_master_link_scheduler: RTL and testbench

- Master-side ACL scheduler that picks which LT_ADDR (1..7) the piconet master addresses in each master TX slot, and what packet type it sends.
- Tracks unacknowledged ACL data per link and per-link poll age.
- Drives ms_lt_addr and the packet type to the ARQ/flow-control and TX encode path.
- Priority order: retransmission, then new data (gated by srcFLOW), then POLL when Tpoll expires.

---
 rtl/acl_master_link_scheduler_if.sv | 38 +++
 rtl/acl_master_link_scheduler.sv | 146 ++++++++++++++
 tb/tb_acl_master_link_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acl_master_link_scheduler_if.sv
// Link-scheduler bus: configuration, slot timing and header-decode inputs plus the grant outputs.
// The master modport is the driving side; the scheduler uses the slave modport.
interface acl_master_link_scheduler_if #(
  parameter int POLL_W = 8
);
  logic              regi_isMaster;
  logic              conns;
  logic [7:0]        regi_link_active;
  logic [7:0]        regi_txdatready;
  logic [3:0]        regi_packet_type;
  logic [POLL_W-1:0] regi_tpoll;
  logic [7:0]        srcFLOW;
  logic              ms_tslot_p;
  logic              ms_TXslot_endp;
  logic              ms_RXslot_endp;
  logic              dec_hecgood;
  logic [2:0]        dec_lt_addr;
  logic [7:0]        dec_arqn;
  logic [2:0]        ms_lt_addr;
  logic [3:0]        sched_pktype;
  logic              sched_valid;
  logic              sched_poll;
  logic [7:0]        acl_outstanding;

  modport master (
    output regi_isMaster, conns, regi_link_active, regi_txdatready, regi_packet_type,
           regi_tpoll, srcFLOW, ms_tslot_p, ms_TXslot_endp, ms_RXslot_endp,
           dec_hecgood, dec_lt_addr, dec_arqn,
    input  ms_lt_addr, sched_pktype, sched_valid, sched_poll, acl_outstanding
  );

  modport slave (
    input  regi_isMaster, conns, regi_link_active, regi_txdatready, regi_packet_type,
           regi_tpoll, srcFLOW, ms_tslot_p, ms_TXslot_endp, ms_RXslot_endp,
           dec_hecgood, dec_lt_addr, dec_arqn,
    output ms_lt_addr, sched_pktype, sched_valid, sched_poll, acl_outstanding
  );
endinterface

// File: rtl/acl_master_link_scheduler.sv
// Master-side ACL slot scheduler: per master TX slot, picks an LT_ADDR by class
// (retransmit > new data > poll) with round-robin inside the class, and tracks unacked data.
module acl_master_link_scheduler #(
  parameter int POLL_W = 8
) (
  input logic                          clk_6M,
  input logic                          rst,
  acl_master_link_scheduler_if.slave   lnk
);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_e;

  state_e            state_q, state_d;
  logic [2:0]        addr_q, addr_d;
  logic [2:0]        rr_q, rr_d;
  logic [3:0]        pkt_q, pkt_d;
  logic              valid_q, valid_d;
  logic              poll_q, poll_d;
  logic              data_q, data_d;
  logic [7:0]        out_q, out_d;
  logic [POLL_W-1:0] age_q [1:7];
  logic [POLL_W-1:0] age_d [1:7];

  logic [7:0] act, el_r, el_d, el_p, el_sel, arqn_hit;
  logic [3:0] cand;
  logic [2:0] pick;
  logic       found, poll_cls, link_ok, grant, acl_type;

  always_comb begin
    act   = lnk.regi_link_active & 8'hFE;
    el_r  = act & out_q;
    el_d  = act & lnk.regi_txdatready & lnk.srcFLOW;
    el_p  = '0;
    for (int unsigned i = 1; i < 8; i++)
      el_p[i] = act[i] && (age_q[i] >= lnk.regi_tpoll);
    poll_cls = ~|el_r & ~|el_d;
    if (|el_r)      el_sel = el_r;
    else if (|el_d) el_sel = el_d;
    else            el_sel = el_p;
    // Round-robin scan over 1..7 beginning just after the last granted address.
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      cand = {1'b0, rr_q} + 4'(k) + 4'd1;
      if (cand > 4'd7) cand = cand - 4'd7;
      if (!found && el_sel[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  assign link_ok  = lnk.conns & lnk.regi_isMaster;
  assign grant    = (state_q == S_IDLE) & lnk.ms_tslot_p & ~lnk.ms_RXslot_endp & link_ok & found;
  assign acl_type = pkt_q inside {4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
  assign arqn_hit = lnk.dec_arqn & act;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    pkt_d   = pkt_q;
    valid_d = valid_q;
    poll_d  = poll_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_TX;
        addr_d  = pick;
        rr_d    = pick;
        valid_d = 1'b1;
        poll_d  = poll_cls;
        data_d  = ~poll_cls;
        pkt_d   = poll_cls ? 4'h1 : lnk.regi_packet_type;
      end
      S_TX: if (!link_ok) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        poll_d  = 1'b0;
      end else if (lnk.ms_TXslot_endp) begin
        state_d = S_RX;
      end
      S_RX: if (!link_ok || lnk.ms_RXslot_endp) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        poll_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      age_d[i] = age_q[i];
      if (!act[i] || !lnk.conns) begin
        out_d[i] = 1'b0;
      end else if ((state_q == S_RX) && link_ok && lnk.ms_RXslot_endp && lnk.dec_hecgood &&
                   (lnk.dec_lt_addr == 3'(i)) && (addr_q == 3'(i)) && arqn_hit[i]) begin
        out_d[i] = 1'b0;
      end else if ((state_q == S_TX) && link_ok && lnk.ms_TXslot_endp && data_q && acl_type &&
                   (addr_q == 3'(i))) begin
        out_d[i] = 1'b1;
      end else begin
        out_d[i] = out_q[i];
      end
      if (!act[i] || (grant && (pick == 3'(i))) ||
          (lnk.ms_RXslot_endp && lnk.dec_hecgood && (lnk.dec_lt_addr == 3'(i))))
        age_d[i] = '0;
      else if (lnk.ms_RXslot_endp && (age_q[i] != '1))
        age_d[i] = age_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rr_q    <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      poll_q  <= 1'b0;
      data_q  <= 1'b0;
      out_q   <= '0;
      for (int unsigned i = 1; i < 8; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
      out_q   <= out_d;
      for (int unsigned i = 1; i < 8; i++) age_q[i] <= age_d[i];
    end
  end

  assign lnk.ms_lt_addr      = addr_q;
  assign lnk.sched_pktype    = pkt_q;
  assign lnk.sched_valid     = valid_q;
  assign lnk.sched_poll      = poll_q;
  assign lnk.acl_outstanding = out_q;

endmodule

// File: tb/tb_acl_master_link_scheduler.sv
// Bench for acl_master_link_scheduler: frame-level reference model feeds a grant scoreboard
// that a separate monitor drains on each rising sched_valid.
module tb_acl_master_link_scheduler;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acl_master_link_scheduler_if #(.POLL_W(PW)) lif ();
  acl_master_link_scheduler #(.POLL_W(PW)) dut (.clk_6M(clk), .rst(rst), .lnk(lif));

  typedef struct packed {
    logic [2:0] a;
    logic [3:0] pt;
    logic       poll;
  } grant_t;

  grant_t exp_q[$];
  int checks = 0;
  int errors = 0;

  bit [7:0] m_out;
  int       m_age[8];
  int       m_rr;
  bit       m_g;
  int       m_a;
  bit       m_data;

  function automatic bit is_acl(input logic [3:0] p);
    return p inside {4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    for (int i = 0; i < 8; i++) m_age[i] = 0;
    m_rr = 0;
    m_g  = 1'b0;
  endtask

  task automatic model_sync();
    for (int i = 1; i < 8; i++)
      if (!lif.regi_link_active[i]) begin
        m_out[i] = 1'b0;
        m_age[i] = 0;
      end
  endtask

  task automatic model_slot();
    int a;
    bit e;
    m_g = 1'b0;
    if (lif.conns && lif.regi_isMaster) begin
      for (int cls = 0; cls < 3; cls++) begin
        for (int k = 1; k < 8; k++) begin
          a = (m_rr + k - 1) % 7 + 1;
          case (cls)
            0:       e = m_out[a];
            1:       e = lif.regi_txdatready[a] & lif.srcFLOW[a];
            default: e = (m_age[a] >= int'(lif.regi_tpoll));
          endcase
          if (!m_g && lif.regi_link_active[a] && e) begin
            m_g    = 1'b1;
            m_a    = a;
            m_data = (cls < 2);
          end
        end
      end
      if (m_g) begin
        grant_t g;
        m_rr       = m_a;
        m_age[m_a] = 0;
        g.a    = 3'(m_a);
        g.pt   = m_data ? lif.regi_packet_type : 4'h1;
        g.poll = ~m_data;
        exp_q.push_back(g);
      end
    end
  endtask

  task automatic model_rxend();
    int maxage;
    maxage = (1 << PW) - 1;
    if (m_g && lif.dec_hecgood && (int'(lif.dec_lt_addr) == m_a) && lif.dec_arqn[m_a])
      m_out[m_a] = 1'b0;
    m_g = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (!lif.regi_link_active[i]) m_age[i] = 0;
      else if (lif.dec_hecgood && (int'(lif.dec_lt_addr) == i)) m_age[i] = 0;
      else if (m_age[i] < maxage) m_age[i] = m_age[i] + 1;
    end
  endtask

  // One master frame: optional slot pulse, TX end, RX end with the given reply header.
  task automatic frame(input bit do_slot, input bit rhec, input logic [2:0] rlt,
                       input logic [7:0] rarqn, input bit to_grant);
    model_sync();
    if (do_slot) begin
      lif.ms_tslot_p = 1'b1;
      model_slot();
    end else begin
      m_g = 1'b0;
    end
    @(negedge clk);
    lif.ms_tslot_p = 1'b0;
    chk("valid_after_slot", 32'(lif.sched_valid), 32'(m_g));
    @(negedge clk);
    @(negedge clk);
    lif.ms_TXslot_endp = 1'b1;
    if (m_g && m_data && is_acl(lif.regi_packet_type)) m_out[m_a] = 1'b1;
    @(negedge clk);
    lif.ms_TXslot_endp = 1'b0;
    lif.dec_hecgood    = rhec;
    lif.dec_lt_addr    = (to_grant && m_g) ? 3'(m_a) : rlt;
    lif.dec_arqn       = rarqn;
    lif.ms_RXslot_endp = 1'b1;
    model_rxend();
    @(negedge clk);
    lif.ms_RXslot_endp = 1'b0;
    lif.dec_hecgood    = 1'b0;
    chk("acl_outstanding", 32'(lif.acl_outstanding), 32'(m_out));
    chk("valid_after_rx", 32'(lif.sched_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (lif.sched_valid && !prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got addr %0d pktype %0h poll %0b, expected no grant",
                   lif.ms_lt_addr, lif.sched_pktype, lif.sched_poll);
        end else begin
          grant_t e;
          e = exp_q.pop_front();
          if (lif.ms_lt_addr !== e.a || lif.sched_pktype !== e.pt || lif.sched_poll !== e.poll) begin
            errors++;
            $display("FAIL grant: got addr %0d pktype %0h poll %0b, expected addr %0d pktype %0h poll %0b",
                     lif.ms_lt_addr, lif.sched_pktype, lif.sched_poll, e.a, e.pt, e.poll);
          end
        end
      end
      prev_v <= lif.sched_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [3:0] pkts [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};

  initial begin
    rst                  = 1'b1;
    lif.regi_isMaster    = 1'b1;
    lif.conns            = 1'b1;
    lif.regi_link_active = '0;
    lif.regi_txdatready  = '0;
    lif.regi_packet_type = 4'h4;
    lif.regi_tpoll       = 2'd3;
    lif.srcFLOW          = 8'hFF;
    lif.ms_tslot_p       = 1'b0;
    lif.ms_TXslot_endp   = 1'b0;
    lif.ms_RXslot_endp   = 1'b0;
    lif.dec_hecgood      = 1'b0;
    lif.dec_lt_addr      = '0;
    lif.dec_arqn         = '0;
    repeat (3) @(negedge clk);
    chk("rst_lt_addr", 32'(lif.ms_lt_addr), 32'd0);
    chk("rst_pktype", 32'(lif.sched_pktype), 32'd0);
    chk("rst_valid", 32'(lif.sched_valid), 32'd0);
    chk("rst_poll", 32'(lif.sched_poll), 32'd0);
    chk("rst_outstanding", 32'(lif.acl_outstanding), 32'd0);
    rst = 1'b0;
    model_reset();

    // Round-robin of new data across links 1,3,5, each reply acknowledges
    lif.regi_link_active = 8'h2A;
    lif.regi_txdatready  = 8'h2A;
    repeat (4) frame(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);

    // Retransmission beats new data; NAK keeps link 3 outstanding, ACK releases it
    lif.regi_txdatready = 8'h28;
    frame(1'b1, 1'b1, 3'd0, 8'h00, 1'b1);
    frame(1'b1, 1'b1, 3'd0, 8'h00, 1'b1);
    frame(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    frame(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);

    // Flow-stopped link only reachable through a POLL once its age reaches tpoll
    do_reset();
    lif.regi_link_active = 8'h20;
    lif.regi_txdatready  = 8'h20;
    lif.srcFLOW          = 8'hDF;
    repeat (5) frame(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    // Empty piconet
    lif.regi_link_active = 8'h00;
    repeat (2) frame(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    // Poll-age saturation: many silent frames without slots, then a POLL, then none
    do_reset();
    lif.srcFLOW          = 8'hFF;
    lif.regi_link_active = 8'h04;
    lif.regi_txdatready  = 8'h00;
    repeat (6) frame(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    frame(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    frame(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    // Randomised frames
    do_reset();
    for (int n = 0; n < 80; n++) begin
      lif.regi_link_active = 8'($urandom);
      lif.regi_txdatready  = 8'($urandom);
      lif.srcFLOW          = 8'($urandom);
      lif.regi_tpoll       = 2'($urandom_range(0, 3));
      lif.regi_packet_type = pkts[$urandom_range(0, 11)];
      frame(1'b1, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
    end

    // conns drop during TX aborts the grant and clears outstanding
    do_reset();
    lif.regi_link_active = 8'h02;
    lif.regi_txdatready  = 8'h02;
    lif.srcFLOW          = 8'hFF;
    lif.regi_packet_type = 4'h4;
    lif.regi_tpoll       = 2'd3;
    frame(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    model_sync();
    lif.ms_tslot_p = 1'b1;
    model_slot();
    @(negedge clk);
    lif.ms_tslot_p = 1'b0;
    chk("abort_conns_granted", 32'(lif.sched_valid), 32'd1);
    lif.conns = 1'b0;
    @(negedge clk);
    lif.conns = 1'b1;
    m_out = '0;
    m_g   = 1'b0;
    chk("abort_conns_valid", 32'(lif.sched_valid), 32'd0);
    chk("abort_conns_outstanding", 32'(lif.acl_outstanding), 32'd0);
    @(negedge clk);

    // rst while in RX returns every output to reset values
    model_sync();
    lif.ms_tslot_p = 1'b1;
    model_slot();
    @(negedge clk);
    lif.ms_tslot_p = 1'b0;
    @(negedge clk);
    lif.ms_TXslot_endp = 1'b1;
    @(negedge clk);
    lif.ms_TXslot_endp = 1'b0;
    chk("pre_rst_outstanding", 32'(lif.acl_outstanding), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rx_rst_lt_addr", 32'(lif.ms_lt_addr), 32'd0);
    chk("rx_rst_pktype", 32'(lif.sched_pktype), 32'd0);
    chk("rx_rst_valid", 32'(lif.sched_valid), 32'd0);
    chk("rx_rst_poll", 32'(lif.sched_poll), 32'd0);
    chk("rx_rst_outstanding", 32'(lif.acl_outstanding), 32'd0);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
